// File: rtl/regfile_pkg.sv
// Shared types and constants for the renaming register file.
package regfile_pkg;

  localparam int unsigned DEF_XLEN           = 32;
  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_TAG_WIDTH      = 5;

  typedef logic [DEF_XLEN-1:0]           xlen_t;
  typedef logic [DEF_REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_TAG_WIDTH-1:0]      rob_tag_t;

  // Architectural register indices with special meaning
  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd2;
  localparam reg_addr_t REG_GP   = 5'd3;

  // Default reset contents of the stack and global pointers
  localparam xlen_t SP_INIT_DEF = 32'h0000_0200;
  localparam xlen_t GP_INIT_DEF = 32'h0000_0100;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy/ROB-tag scoreboard: one busy bit and producer tag per register.
// Commit clears busy only on a tag match; allocate overrides commit;
// flush clears every busy bit and suppresses same-cycle allocates.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD         = 4,
  parameter int NUM_WR         = 2,
  parameter int NUM_AL         = 2,
  parameter int TAG_WIDTH      = 5
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [NUM_AL-1:0]                al_en,
  input  logic [NUM_AL*REG_ADDR_WIDTH-1:0] al_addr,
  input  logic [NUM_AL*TAG_WIDTH-1:0]      al_tag,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*TAG_WIDTH-1:0]      wr_tag,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]                rd_busy,
  output logic [NUM_RD*TAG_WIDTH-1:0]      rd_tag
);

  localparam int DEPTH = 2**REG_ADDR_WIDTH;
  localparam int RAW   = REG_ADDR_WIDTH;
  localparam int TW    = TAG_WIDTH;

  logic [DEPTH-1:0] w_busy_all;
  logic [TW-1:0]    w_tag_all [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    if (gi == int'(REG_ZERO)) begin : g_zero
      assign w_busy_all[gi] = 1'b0;
      assign w_tag_all[gi]  = '0;
    end else begin : g_live
      logic          r_busy_reg;
      logic          w_busy_next;
      logic [TW-1:0] r_tag_reg;
      logic [TW-1:0] w_tag_next;

      // Priority: tag-matched commit clears, then flush clears, then allocate (highest port last) sets
      always_comb begin
        w_busy_next = r_busy_reg;
        w_tag_next  = r_tag_reg;
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_addr[w*RAW +: RAW] == RAW'(gi) &&
              wr_tag[w*TW +: TW] == r_tag_reg) begin
            w_busy_next = 1'b0;
          end
        end
        if (flush) begin
          w_busy_next = 1'b0;
        end else begin
          for (int a = 0; a < NUM_AL; a++) begin
            if (al_en[a] && al_addr[a*RAW +: RAW] == RAW'(gi)) begin
              w_busy_next = 1'b1;
              w_tag_next  = al_tag[a*TW +: TW];
            end
          end
        end
      end

      // Busy/tag state; reset drops every pending allocation
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy_reg <= 1'b0;
          r_tag_reg  <= '0;
        end else begin
          r_busy_reg <= w_busy_next;
          r_tag_reg  <= w_tag_next;
        end
      end

      assign w_busy_all[gi] = r_busy_reg;
      assign w_tag_all[gi]  = r_tag_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    assign rd_busy[gi]            = w_busy_all[rd_addr[gi*RAW +: RAW]];
    assign rd_tag[gi*TW +: TW]    = w_tag_all[rd_addr[gi*RAW +: RAW]];
  end

endmodule

// File: rtl/regfile_rename.sv
// Multi-port integer register file with busy/ROB-tag scoreboard.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle commit data
// to matching read ports; without it reads see pre-edge contents.
module regfile_rename
  import regfile_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_RD         = 4,
  parameter int NUM_WR         = 2,
  parameter int NUM_AL         = 2,
  parameter int TAG_WIDTH      = 5,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(SP_INIT_DEF),
  parameter logic [XLEN-1:0] GP_INIT = XLEN'(GP_INIT_DEF)
)(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_RD*XLEN-1:0]           r_data,
  output logic [NUM_RD-1:0]                r_busy,
  output logic [NUM_RD*TAG_WIDTH-1:0]      r_tag,
  input  logic [NUM_AL-1:0]                al_en,
  input  logic [NUM_AL*REG_ADDR_WIDTH-1:0] al_addr,
  input  logic [NUM_AL*TAG_WIDTH-1:0]      al_tag,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*XLEN-1:0]           wr_data,
  input  logic [NUM_WR*TAG_WIDTH-1:0]      wr_tag,
  input  logic                             flush
);

  localparam int DEPTH = 2**REG_ADDR_WIDTH;
  localparam int RAW   = REG_ADDR_WIDTH;
  localparam int TW    = TAG_WIDTH;

  logic [XLEN-1:0]        w_data_all [DEPTH];
  logic [NUM_RD-1:0]      w_sb_busy;
  logic [NUM_RD*TW-1:0]   w_sb_tag;

  regfile_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_RD         (NUM_RD),
    .NUM_WR         (NUM_WR),
    .NUM_AL         (NUM_AL),
    .TAG_WIDTH      (TAG_WIDTH)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .al_en   (al_en),
    .al_addr (al_addr),
    .al_tag  (al_tag),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_tag  (wr_tag),
    .rd_addr (r_addr),
    .rd_busy (w_sb_busy),
    .rd_tag  (w_sb_tag)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == int'(REG_ZERO)) begin : g_zero
      assign w_data_all[gi] = '0;
    end else begin : g_live
      localparam logic [XLEN-1:0] INIT = (gi == int'(REG_SP)) ? SP_INIT :
                                         (gi == int'(REG_GP)) ? GP_INIT : '0;
      logic [XLEN-1:0] r_data_reg;
      logic [XLEN-1:0] w_data_next;

      // Commit write select: the highest-indexed matching port wins
      always_comb begin
        w_data_next = r_data_reg;
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_addr[w*RAW +: RAW] == RAW'(gi)) begin
            w_data_next = wr_data[w*XLEN +: XLEN];
          end
        end
      end

      // Register storage with per-register reset value
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_data_reg <= INIT;
        else     r_data_reg <= w_data_next;
      end

      assign w_data_all[gi] = r_data_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [RAW-1:0] w_ra;
    assign w_ra = r_addr[gi*RAW +: RAW];
    assign r_tag[gi*TW +: TW] = w_sb_tag[gi*TW +: TW];
`ifdef REGFILE_BYPASS_EN
    logic [XLEN-1:0] w_rd_data;
    logic            w_rd_clr;

    // Forward same-cycle commit data; a tag-matched commit also hides busy
    always_comb begin
      w_rd_data = w_data_all[w_ra];
      w_rd_clr  = 1'b0;
      if (w_ra != '0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && wr_addr[w*RAW +: RAW] == w_ra) begin
            w_rd_data = wr_data[w*XLEN +: XLEN];
            if (wr_tag[w*TW +: TW] == w_sb_tag[gi*TW +: TW]) w_rd_clr = 1'b1;
          end
        end
      end
    end

    assign r_data[gi*XLEN +: XLEN] = w_rd_data;
    assign r_busy[gi]              = w_sb_busy[gi] & ~w_rd_clr;
`else
    assign r_data[gi*XLEN +: XLEN] = w_data_all[w_ra];
    assign r_busy[gi]              = w_sb_busy[gi];
`endif
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed table, hand sequences,
// randomized traffic against a behavioural model, and mid-cycle reset.
module tb_regfile_rename;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0][4:0]  r_addr;
  logic [3:0][31:0] r_data;
  logic [3:0]       r_busy;
  logic [3:0][4:0]  r_tag;
  logic [1:0]       al_en;
  logic [1:0][4:0]  al_addr;
  logic [1:0][4:0]  al_tag;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0][4:0]  wr_tag;
  logic             flush;

  regfile_rename dut (
    .clk(clk), .rst(rst),
    .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy), .r_tag(r_tag),
    .al_en(al_en), .al_addr(al_addr), .al_tag(al_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
    .flush(flush)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model of the architectural state
  logic [31:0] m_data [32];
  logic        m_busy [32];
  logic [4:0]  m_tag  [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = 32'h0; m_busy[i] = 1'b0; m_tag[i] = 5'h0;
    end
    m_data[2] = 32'h200;
    m_data[3] = 32'h100;
  endfunction

  function automatic void model_step();
    logic clr [32];
    for (int i = 0; i < 32; i++) clr[i] = 1'b0;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_addr[w] != 0 && m_busy[wr_addr[w]] && m_tag[wr_addr[w]] == wr_tag[w])
        clr[wr_addr[w]] = 1'b1;
    for (int w = 0; w < 2; w++)
      if (wr_en[w] && wr_addr[w] != 0) m_data[wr_addr[w]] = wr_data[w];
    for (int i = 0; i < 32; i++) if (clr[i]) m_busy[i] = 1'b0;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      for (int a = 0; a < 2; a++)
        if (al_en[a] && al_addr[a] != 0) begin
          m_busy[al_addr[a]] = 1'b1;
          m_tag[al_addr[a]]  = al_tag[a];
        end
    end
  endfunction

  function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                     output logic b, output logic [4:0] t);
    d = m_data[a]; b = m_busy[a]; t = m_tag[a];
    if (a == 0) begin d = 0; b = 0; t = 0; end
`ifdef REGFILE_BYPASS_EN
    if (a != 0)
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w] == a) begin
          d = wr_data[w];
          if (wr_tag[w] == m_tag[a]) b = 1'b0;
        end
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    al_en = '0; al_addr = '0; al_tag = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0; wr_tag = '0;
    flush = 1'b0;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_ports(input string nm);
    logic [31:0] d; logic b; logic [4:0] t;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      model_read(r_addr[p], d, b, t);
      chk($sformatf("%s_data p%0d x%0d", nm, p, r_addr[p]), r_data[p], d);
      chk($sformatf("%s_busy p%0d x%0d", nm, p, r_addr[p]), 32'(r_busy[p]), 32'(b));
      if (b) chk($sformatf("%s_tag p%0d x%0d", nm, p, r_addr[p]), 32'(r_tag[p]), 32'(t));
    end
  endtask

  typedef struct {
    logic [4:0] rd; logic al; logic [4:0] aa; logic [4:0] at;
    logic [1:0] we; logic [4:0] wa0; logic [31:0] wd0; logic [4:0] wt0;
    logic [4:0] wa1; logic [31:0] wd1; logic [4:0] wt1;
    logic [31:0] ed; logic eb; logic [4:0] et;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rd, input logic al, input logic [4:0] aa,
      input logic [4:0] at, input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
      input logic [4:0] wt0, input logic [4:0] wa1, input logic [31:0] wd1, input logic [4:0] wt1,
      input logic [31:0] ed, input logic eb, input logic [4:0] et);
    vec_t v;
    v.rd = rd; v.al = al; v.aa = aa; v.at = at; v.we = we;
    v.wa0 = wa0; v.wd0 = wd0; v.wt0 = wt0; v.wa1 = wa1; v.wd1 = wd1; v.wt1 = wt1;
    v.ed = ed; v.eb = eb; v.et = et;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    logic [31:0] d; logic b; logic [4:0] t;
    idle();
    r_addr = '0;
    model_reset();

    // Directed table: read port 0 checked against pre-edge state of each row
    vecs[0]  = mk(2, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0);
    vecs[1]  = mk(3, 1, 5, 3, 2'b00, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0);
    vecs[2]  = mk(5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 1, 3);
    vecs[3]  = mk(3, 0, 0, 0, 2'b01, 5, 32'hDEADBEEF, 3, 0, 0, 0, 32'h100, 0, 0);
    vecs[4]  = mk(5, 1, 7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    vecs[5]  = mk(7, 1, 7, 4, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    vecs[6]  = mk(7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 1, 4);
    vecs[7]  = mk(0, 0, 0, 0, 2'b01, 7, 32'h77, 1, 0, 0, 0, 32'h0, 0, 0);
    vecs[8]  = mk(7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h77, 1, 4);
    vecs[9]  = mk(0, 0, 0, 0, 2'b01, 7, 32'h78, 4, 0, 0, 0, 32'h0, 0, 0);
    vecs[10] = mk(7, 1, 9, 2, 2'b11, 9, 32'h55, 0, 9, 32'hAA, 0, 32'h78, 0, 0);
    vecs[11] = mk(9, 1, 0, 6, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 32'hAA, 1, 2);
    vecs[12] = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      idle();
      al_en[0] = vecs[i].al; al_addr[0] = vecs[i].aa; al_tag[0] = vecs[i].at;
      wr_en = vecs[i].we;
      wr_addr[0] = vecs[i].wa0; wr_data[0] = vecs[i].wd0; wr_tag[0] = vecs[i].wt0;
      wr_addr[1] = vecs[i].wa1; wr_data[1] = vecs[i].wd1; wr_tag[1] = vecs[i].wt1;
      r_addr[0] = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_data", i), r_data[0], vecs[i].ed);
      chk($sformatf("vec%0d_busy", i), 32'(r_busy[0]), 32'(vecs[i].eb));
      if (vecs[i].eb || vecs[i].rd == 0)
        chk($sformatf("vec%0d_tag", i), 32'(r_tag[0]), 32'(vecs[i].et));
      cycle_end();
    end

    // Same-cycle commit and read of x4
    idle(); al_en[0] = 1'b1; al_addr[0] = 5'd4; al_tag[0] = 5'd8;
    cycle_end();
    idle(); wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h1234; wr_tag[0] = 5'd8;
    r_addr[0] = 5'd4;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", r_data[0], 32'h1234);
    chk("bypass_busy", 32'(r_busy[0]), 32'd0);
`else
    chk("nobypass_data", r_data[0], 32'h0);
    chk("nobypass_busy", 32'(r_busy[0]), 32'd1);
`endif
    cycle_end();
    idle(); r_addr[0] = 5'd4;
    @(negedge clk);
    chk("commit_next_data", r_data[0], 32'h1234);
    chk("commit_next_busy", 32'(r_busy[0]), 32'd0);
    cycle_end();

    // Busy on x1..x31, then flush with a same-cycle allocate and commit
    for (int r = 1; r < 32; r += 2) begin
      idle();
      al_en[0] = 1'b1; al_addr[0] = 5'(r); al_tag[0] = 5'(r);
      al_en[1] = (r + 1 < 32); al_addr[1] = 5'(r + 1); al_tag[1] = 5'(r + 1);
      cycle_end();
    end
    idle(); r_addr[0] = 5'd31;
    @(negedge clk);
    chk("preflush_busy x31", 32'(r_busy[0]), 32'd1);
    chk("preflush_tag x31", 32'(r_tag[0]), 32'd31);
    flush = 1'b1; al_en[0] = 1'b1; al_addr[0] = 5'd10; al_tag[0] = 5'd5;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd12; wr_data[0] = 32'hC0DE; wr_tag[0] = 5'd3;
    cycle_end();
    idle();
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < 4; p++) r_addr[p] = 5'(g * 4 + p);
      @(negedge clk);
      for (int p = 0; p < 4; p++)
        chk($sformatf("flush_busy x%0d", g * 4 + p), 32'(r_busy[p]), 32'd0);
    end
    r_addr[0] = 5'd12;
    @(negedge clk);
    chk("flush_commit_data x12", r_data[0], 32'hC0DE);
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int a = 0; a < 2; a++) begin
        al_en[a]   = ($urandom_range(0, 3) == 0);
        al_addr[a] = 5'($urandom_range(0, 7));
        al_tag[a]  = 5'($urandom_range(0, 31));
      end
      for (int w = 0; w < 2; w++) begin
        wr_en[w]   = ($urandom_range(0, 1) == 1);
        wr_addr[w] = 5'($urandom_range(0, 7));
        wr_data[w] = $urandom;
        wr_tag[w]  = ($urandom_range(0, 1) == 1) ? m_tag[wr_addr[w]] : 5'($urandom_range(0, 31));
      end
      flush = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 4; p++)
        r_addr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      check_ports("rand");
      cycle_end();
    end

    // Asynchronous reset mid-cycle with a pending allocation
    idle(); al_en[0] = 1'b1; al_addr[0] = 5'd20; al_tag[0] = 5'd9;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd6; wr_data[0] = 32'hFEED; wr_tag[0] = 5'd0;
    cycle_end();
    idle();
    rst = 1'b1;
    for (int g = 0; g < 8; g++) begin
      for (int p = 0; p < 4; p++) r_addr[p] = 5'(g * 4 + p);
      #1;
      for (int p = 0; p < 4; p++) begin
        d = (g * 4 + p == 2) ? 32'h200 : (g * 4 + p == 3) ? 32'h100 : 32'h0;
        chk($sformatf("rst_data x%0d", g * 4 + p), r_data[p], d);
        chk($sformatf("rst_busy x%0d", g * 4 + p), 32'(r_busy[p]), 32'd0);
        chk($sformatf("rst_tag x%0d", g * 4 + p), 32'(r_tag[p]), 32'd0);
      end
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    r_addr[0] = 5'd20; r_addr[1] = 5'd6; r_addr[2] = 5'd2; r_addr[3] = 5'd0;
    check_ports("postrst");
    model_read(5'd20, d, b, t);
    chk("postrst_model_x20_busy", 32'(r_busy[0]), 32'(b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
